// File: rtl/pocket_i2s_rx.sv
// rtl/pocket_i2s_rx.sv - I2S stereo receiver with ready/valid pair output
//
// Purpose: oversamples an external I2S bus (sclk/lrck/data) in the clk_sys
// domain, frames left/right slots, captures the first DW bits of each slot
// MSB-first and presents complete stereo pairs with a valid/ready handshake.
//
// Ports:
//   clk_sys     in   core clock, all logic on rising edge (>= 4x audio_sclk)
//   reset       in   synchronous active-high reset
//   audio_sclk  in   I2S bit clock (asynchronous)
//   audio_lrck  in   L/R select, 0 = left, 1 = right (asynchronous)
//   audio_dac   in   serial data, MSB first (asynchronous)
//   audio_l     out  [DW-1:0] last complete left sample
//   audio_r     out  [DW-1:0] last complete right sample
//   out_valid   out  stereo pair available
//   out_ready   in   consumer accepts pair when out_valid && out_ready
//   overrun     out  sticky: an unaccepted pair was overwritten
//   frame_err   out  one-cycle pulse on framing violation
//
// Configuration: define POCKET_I2S_RX_FRAMECHK_EN to enable frame checking
// (slot length must be 32 sclk, runaway slots abort). Without it frame_err
// is constant 0 and the framer never falls back to SYNC.

module pocket_i2s_rx #(
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          audio_sclk,
  input  logic          audio_lrck,
  input  logic          audio_dac,
  output logic [DW-1:0] audio_l,
  output logic [DW-1:0] audio_r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun,
  output logic          frame_err
);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  localparam logic [5:0] K_LAST = 6'(DW);
  localparam logic [5:0] K_MAX  = 6'd63;
`ifdef POCKET_I2S_RX_FRAMECHK_EN
  localparam logic [5:0] K_SLOT_END = 6'd31;
`endif

  // Synchronizers; sclk gets a third stage for rising-edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic lrck_s1_q, lrck_s2_q;
  logic dac_s1_q, dac_s2_q;

  logic          lr_prev_q, lr_prev_d;
  logic [5:0]    k_q, k_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] hold_l_q, hold_l_d;
  logic [DW-1:0] hold_r_q, hold_r_d;
  logic          left_got_q, left_got_d;
  logic          load_q, load_d;
  logic [DW-1:0] audio_l_q, audio_l_d;
  logic [DW-1:0] audio_r_q, audio_r_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic          sclk_rise;
  logic          boundary;
  logic [5:0]    k_edge;
  logic [DW:0]   shift_ext;
  logic [DW-1:0] shift_in;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign boundary  = lrck_s2_q != lr_prev_q;
  // Edge index of the current sclk rise: 0 at a channel boundary, else saturating count.
  assign k_edge    = boundary ? 6'd0 : ((k_q == K_MAX) ? K_MAX : k_q + 6'd1);
  // Widened concat keeps the shift legal for DW=1.
  assign shift_ext = {shift_q, dac_s2_q};
  assign shift_in  = shift_ext[DW-1:0];

  always_comb begin
    lr_prev_d   = lr_prev_q;
    k_d         = k_q;
    state_d     = state_q;
    shift_d     = shift_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    left_got_d  = left_got_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;

    if (sclk_rise) begin
      lr_prev_d = lrck_s2_q;
      k_d       = k_edge;

      if (state_q != ST_SYNC && k_edge != 6'd0 && k_edge <= K_LAST) begin
        shift_d = shift_in;
        if (k_edge == K_LAST) begin
          if (lrck_s2_q) begin
            hold_r_d = shift_in;
            // Only a right slot that follows a left slot of the same frame emits a pair.
            if (left_got_q) begin
              load_d     = 1'b1;
              left_got_d = 1'b0;
            end
          end else begin
            hold_l_d   = shift_in;
            left_got_d = 1'b1;
          end
        end
      end

      if (boundary) begin
        if (state_q == ST_SYNC) begin
          if (!lrck_s2_q) begin
            state_d    = ST_LEFT;
            left_got_d = 1'b0;
          end
        end else begin
`ifdef POCKET_I2S_RX_FRAMECHK_EN
          if (k_q != K_SLOT_END) begin
            state_d     = ST_SYNC;
            left_got_d  = 1'b0;
            frame_err_d = 1'b1;
          end else
`endif
          if (lrck_s2_q) begin
            state_d = ST_RIGHT;
          end else begin
            state_d    = ST_LEFT;
            left_got_d = 1'b0;
          end
        end
      end
`ifdef POCKET_I2S_RX_FRAMECHK_EN
      else if (state_q != ST_SYNC && k_edge == K_MAX && k_q != K_MAX) begin
        // Slot ran away without a boundary: abandon the frame.
        state_d     = ST_SYNC;
        left_got_d  = 1'b0;
        frame_err_d = 1'b1;
      end
`endif
    end
  end

  // Output handshake: a load always wins; it flags overrun only when the
  // pair it replaces is neither accepted nor already consumed.
  always_comb begin
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (load_q) begin
      audio_l_d   = hold_l_q;
      audio_r_d   = hold_r_q;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      dac_s1_q    <= 1'b0;
      dac_s2_q    <= 1'b0;
      lr_prev_q   <= 1'b0;
      k_q         <= 6'd0;
      state_q     <= ST_SYNC;
      shift_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      left_got_q  <= 1'b0;
      load_q      <= 1'b0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_s1_q   <= audio_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      lrck_s1_q   <= audio_lrck;
      lrck_s2_q   <= lrck_s1_q;
      dac_s1_q    <= audio_dac;
      dac_s2_q    <= dac_s1_q;
      lr_prev_q   <= lr_prev_d;
      k_q         <= k_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      left_got_q  <= left_got_d;
      load_q      <= load_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign audio_l   = audio_l_q;
  assign audio_r   = audio_r_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pocket_i2s_rx.sv
// tb/tb_pocket_i2s_rx.sv - directed bench for pocket_i2s_rx (DW=16 and DW=12)
`timescale 1ns/1ps

module tb_pocket_i2s_rx;

  localparam real CLK_HALF  = 6.734;    // 74.25 MHz
  localparam real SCLK_HALF = 162.76;   // 3.072 MHz

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic audio_sclk = 1'b0;
  logic audio_lrck = 1'b0;
  logic audio_dac = 1'b0;
  logic out_ready = 1'b1;

  logic [15:0] l16, r16;
  logic        v16, ovr16, ferr16;
  logic [11:0] l12, r12;
  logic        v12, ovr12, ferr12;

  int errors = 0;
  int checks = 0;

  int          vcnt16 = 0;
  int          ecnt16 = 0;
  logic [15:0] last_l16 = '0, last_r16 = '0;
  logic [11:0] last_l12 = '0, last_r12 = '0;

  int base_v, base_e;
  int exp_v, exp_e;

  always #(CLK_HALF) clk_sys = ~clk_sys;

  pocket_i2s_rx #(.DW(16)) u_dut16 (
    .clk_sys(clk_sys), .reset(reset), .audio_sclk(audio_sclk),
    .audio_lrck(audio_lrck), .audio_dac(audio_dac), .audio_l(l16),
    .audio_r(r16), .out_valid(v16), .out_ready(out_ready),
    .overrun(ovr16), .frame_err(ferr16)
  );

  pocket_i2s_rx #(.DW(12)) u_dut12 (
    .clk_sys(clk_sys), .reset(reset), .audio_sclk(audio_sclk),
    .audio_lrck(audio_lrck), .audio_dac(audio_dac), .audio_l(l12),
    .audio_r(r12), .out_valid(v12), .out_ready(out_ready),
    .overrun(ovr12), .frame_err(ferr12)
  );

  // Passive monitor on the opposite edge: counts valid cycles / error pulses, keeps last pair.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (v16) begin
        vcnt16   <= vcnt16 + 1;
        last_l16 <= l16;
        last_r16 <= r16;
      end
      if (ferr16) ecnt16 <= ecnt16 + 1;
      if (v12) begin
        last_l12 <= l12;
        last_r12 <= r12;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 32-bit slot: edge 0 is the I2S delay bit, edges 1..16 carry the sample MSB first, rest pad.
  task automatic send_bits(input logic lr, input logic [15:0] s, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      audio_sclk = 1'b0;
      audio_lrck = lr;
      audio_dac  = (i >= 1 && i <= 16) ? s[16-i] : 1'b0;
      #(SCLK_HALF);
      audio_sclk = 1'b1;
      #(SCLK_HALF);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_bits(1'b0, l, 0, 31);
    send_bits(1'b1, r, 0, 31);
  endtask

  initial begin
    // Reset state
    repeat (5) @(posedge clk_sys);
    #1;
    chk("rst_audio_l", 32'(l16), 32'h0);
    chk("rst_audio_r", 32'(r16), 32'h0);
    chk("rst_out_valid", 32'(v16), 32'h0);
    chk("rst_overrun", 32'(ovr16), 32'h0);
    chk("rst_frame_err", 32'(ferr16), 32'h0);
    chk("rst_dw12_l", 32'(l12), 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk_sys);

    // Basic frame with out_ready=1: one valid pulse per frame
    out_ready = 1'b1;
    send_bits(1'b1, 16'h0000, 0, 31);
    base_v = vcnt16;
    send_frame(16'hA5C3, 16'h1234);
    chk("basic_valid_pulses", 32'(vcnt16 - base_v), 32'd1);
    chk("basic_audio_l", 32'(last_l16), 32'hA5C3);
    chk("basic_audio_r", 32'(last_r16), 32'h1234);
    base_v = vcnt16;
    send_frame(16'hA5C3, 16'h1234);
    chk("basic2_valid_pulses", 32'(vcnt16 - base_v), 32'd1);
    chk("basic_out_valid_low", 32'(v16), 32'h0);

    // DW=12 truncation: first 12 bits of each slot
    send_frame(16'hFFF0, 16'h0ABC);
    chk("dw12_audio_l", 32'(last_l12), 32'hFFF);
    chk("dw12_audio_r", 32'(last_r12), 32'h0AB);
    chk("dw16_audio_l_fff0", 32'(last_l16), 32'hFFF0);
    chk("dw16_audio_r_0abc", 32'(last_r16), 32'h0ABC);

    // Overrun: two frames without acceptance
    out_ready = 1'b0;
    send_frame(16'h0001, 16'h0002);
    chk("ovr_first_valid", 32'(v16), 32'h1);
    chk("ovr_first_flag", 32'(ovr16), 32'h0);
    send_frame(16'h0003, 16'h0004);
    chk("ovr_audio_l", 32'(l16), 32'h0003);
    chk("ovr_audio_r", 32'(r16), 32'h0004);
    chk("ovr_out_valid", 32'(v16), 32'h1);
    chk("ovr_overrun", 32'(ovr16), 32'h1);
    @(negedge clk_sys);
    out_ready = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("ovr_accept_clears_valid", 32'(v16), 32'h0);
    chk("ovr_sticky", 32'(ovr16), 32'h1);

    // Reset mid-right-half: partial frame discarded, next full frame output
    send_bits(1'b0, 16'h7777, 0, 31);
    send_bits(1'b1, 16'h8888, 0, 9);
    reset = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("midrst_overrun_cleared", 32'(ovr16), 32'h0);
    reset = 1'b0;
    base_v = vcnt16;
    send_bits(1'b1, 16'h8888, 10, 31);
    chk("midrst_no_valid_partial", 32'(vcnt16 - base_v), 32'd0);
    send_frame(16'h1111, 16'h2222);
    chk("midrst_valid_pulses", 32'(vcnt16 - base_v), 32'd1);
    chk("midrst_audio_l", 32'(last_l16), 32'h1111);
    chk("midrst_audio_r", 32'(last_r16), 32'h2222);

    // Accept on the load cycle: valid stays high, no overrun.
    // Sclk rise is aligned just after a clk edge; load lands on the 4th edge after it.
    out_ready = 1'b0;
    send_frame(16'h0005, 16'h0006);
    chk("simul_held_valid", 32'(v16), 32'h1);
    send_bits(1'b0, 16'h0009, 0, 31);
    send_bits(1'b1, 16'h000A, 0, 15);
    audio_sclk = 1'b0;
    audio_dac  = 1'b0;  // bit 0 of 16'h000A
    #(SCLK_HALF);
    @(posedge clk_sys);
    #1 audio_sclk = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 out_ready = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("simul_out_valid", 32'(v16), 32'h1);
    chk("simul_overrun", 32'(ovr16), 32'h0);
    chk("simul_audio_l", 32'(l16), 32'h0009);
    chk("simul_audio_r", 32'(r16), 32'h000A);
    #(SCLK_HALF);
    send_bits(1'b1, 16'h000A, 17, 31);

    // Short left slot (30 sclk)
    base_v = vcnt16;
    base_e = ecnt16;
    send_bits(1'b0, 16'hBEEF, 0, 29);
    send_bits(1'b1, 16'hCAFE, 0, 31);
    send_frame(16'h1357, 16'h2468);
`ifdef POCKET_I2S_RX_FRAMECHK_EN
    exp_e = 1;
    exp_v = 1;
`else
    exp_e = 0;
    exp_v = 2;
`endif
    chk("framechk_err_pulses", 32'(ecnt16 - base_e), 32'(exp_e));
    chk("framechk_valid_pulses", 32'(vcnt16 - base_v), 32'(exp_v));
    chk("framechk_audio_l", 32'(last_l16), 32'h1357);
    chk("framechk_audio_r", 32'(last_r16), 32'h2468);
    chk("framechk_overrun", 32'(ovr16), 32'h0);

    repeat (4) @(posedge clk_sys);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
